dmem_dump_reader: RTL and testbench

- Debug readout engine for the RISC-V core's data memory, attached to a spare read port of data_mem.
- On a start pulse it reads a contiguous range of 32-bit words and streams them out as bytes over a valid/ready byte channel, for example to a UART TX or a host bridge.
- It is the read-back counterpart of the memory preload path: a bench or host can pull the post-execution memory contents through hardware instead of by hierarchical peeking.

---
 rtl/dmem_dump_reader.sv | 178 +++++++++++++++++
 tb/tb_dmem_dump_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader
//   Debug readout engine for the core's data memory. On a start pulse it
//   reads word_count consecutive 32-bit words from a spare data_mem read port
//   and streams them as little-endian bytes over a valid/ready channel.
//
// Optional feature (macro DUMP_CHECKSUM_EN): after the last data byte one
//   extra byte carrying the XOR of all data bytes is sent, and out_last marks
//   that byte instead. With word_count=0 the checksum byte (0x00) is still sent.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   start       one-cycle request, sampled only when idle
//   base_addr   byte address of the first word (low 2 bits ignored)
//   word_count  number of 32-bit words to dump
//   busy        high while a dump is in progress (through the DONE cycle)
//   done        one-cycle completion pulse
//   mem_rd_en   read strobe to data memory (one cycle per word)
//   mem_addr    word-aligned byte address, holds its last value
//   mem_rdata   read data, valid one cycle after mem_rd_en
//   out_valid   byte channel valid
//   out_ready   byte channel ready
//   out_byte    streamed byte
//   out_last    marks the final byte of the dump
module dmem_dump_reader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_q;     // drives mem_addr; only moves when a new read is due
  logic [CNT_W-1:0]  rem;
  logic [1:0]        idx;
  logic [31:0]       word;
  logic [7:0]        data_byte;
  logic [ADDR_W-1:0] aligned_base;
  logic [ADDR_W-1:0] next_addr;
  logic              send;
  logic              hs;
  logic              last_data;

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] cks;
  logic       cks_phase;         // SEND is presenting the checksum byte
`endif

  // Masking keeps every base_addr bit in the expression while forcing alignment.
  assign aligned_base = base_addr & ~ADDR_W'(3);
  assign next_addr    = addr + ADDR_W'(4);

  assign send      = (state == S_SEND);
  assign hs        = send && out_ready;
  assign last_data = (idx == 2'd3) && (rem == CNT_W'(1));

  always_comb begin
    data_byte = '0;
    case (idx)
      2'd0:    data_byte = word[7:0];
      2'd1:    data_byte = word[15:8];
      2'd2:    data_byte = word[23:16];
      default: data_byte = word[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      addr   <= '0;
      addr_q <= '0;
      rem    <= '0;
      idx    <= '0;
      word   <= '0;
`ifdef DUMP_CHECKSUM_EN
      cks       <= '0;
      cks_phase <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
`ifdef DUMP_CHECKSUM_EN
            cks <= '0;
`endif
            if (word_count != '0) begin
              addr   <= aligned_base;
              addr_q <= aligned_base;
              rem    <= word_count;
              state  <= S_READ;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              // Empty dump still carries its (zero) checksum byte.
              cks_phase <= 1'b1;
              state     <= S_SEND;
`else
              state <= S_DONE;
`endif
            end
          end
        end
        S_READ: state <= S_WAIT;
        S_WAIT: begin
          word  <= mem_rdata;
          idx   <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (hs) begin
`ifdef DUMP_CHECKSUM_EN
            if (cks_phase) begin
              cks_phase <= 1'b0;
              state     <= S_DONE;
            end else begin
              cks <= cks ^ data_byte;
`endif
              idx <= idx + 2'd1;
              if (idx == 2'd3) begin
                rem  <= rem - CNT_W'(1);
                addr <= next_addr;
                if (rem == CNT_W'(1)) begin
`ifdef DUMP_CHECKSUM_EN
                  cks_phase <= 1'b1;
`else
                  state <= S_DONE;
`endif
                end else begin
                  addr_q <= next_addr;
                  state  <= S_READ;
                end
              end
`ifdef DUMP_CHECKSUM_EN
            end
`endif
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state so the async reset clears them at once.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mem_rd_en = (state == S_READ);
  assign mem_addr  = addr_q;
  assign out_valid = send;

`ifdef DUMP_CHECKSUM_EN
  assign out_byte = send ? (cks_phase ? cks : data_byte) : '0;
  assign out_last = send && cks_phase;
`else
  assign out_byte = send ? data_byte : '0;
  assign out_last = send && last_data;
`endif

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed bench for dmem_dump_reader: a one-cycle-latency memory model,
// a negedge channel monitor, and hand-built expected byte/address streams.
module tb_dmem_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        busy, done, mem_rd_en;
  logic [31:0] mem_addr, mem_rdata;
  logic        out_valid, out_ready;
  logic [7:0]  out_byte;
  logic        out_last;

  always #5 clk = ~clk;

  dmem_dump_reader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last)
  );

  logic [31:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr[9:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor (sole writer of these logs)
  logic [7:0]  byte_q [$];
  logic        last_q [$];
  logic [31:0] addr_q [$];
  int          rise_q [$];
  int done_n = 0, done_cyc = 0, last_hs_cyc = 0;
  int rd_err = 0, stab_err = 0, stall_seen = 0;
  logic       pv = 1'b0, pr = 1'b0, prd = 1'b0, plast = 1'b0;
  logic [7:0] pbyte = '0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      byte_q.push_back(out_byte);
      last_q.push_back(out_last);
      last_hs_cyc = cyc;
    end
    if (out_valid && !pv) rise_q.push_back(cyc);
    if (mem_rd_en) addr_q.push_back(mem_addr);
    if (mem_rd_en && prd) rd_err++;
    if (done) begin done_n++; done_cyc = cyc; end
    if (rst && pv && !pr) begin
      stall_seen++;
      if (!out_valid || out_byte != pbyte || out_last != plast) stab_err++;
    end
    pv = out_valid; pr = out_ready; prd = mem_rd_en; pbyte = out_byte; plast = out_last;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  logic [7:0]  exp_b [$];
  logic [31:0] exp_a [$];
  logic [7:0]  exp_cks;
  int b0, a0, r0, d0, s0, start_cyc;
  bit rst_hit;

  task automatic exp_clear();
    exp_b.delete(); exp_a.delete(); exp_cks = '0;
  endtask

  task automatic exp_word(input logic [31:0] a, input logic [31:0] w);
    exp_a.push_back(a);
    for (int unsigned i = 0; i < 4; i++) begin
      exp_b.push_back(w[8*i +: 8]);
      exp_cks = exp_cks ^ w[8*i +: 8];
    end
  endtask

  task automatic exp_finish();
`ifdef DUMP_CHECKSUM_EN
    exp_b.push_back(exp_cks);
`endif
  endtask

  task automatic run_dump(input logic [31:0] base, input logic [15:0] cnt,
                          input int stall_len, input bit do_reset, input bit poke);
    int t, stalled;
    b0 = byte_q.size(); a0 = addr_q.size(); r0 = rise_q.size();
    d0 = done_n; s0 = stall_seen;
    @(posedge clk); #1;
    base_addr = base; word_count = cnt; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0; stalled = 0; rst_hit = 0;
    while (done_n == d0 && t < 400 && !rst_hit) begin
      if (stall_len > 0 && byte_q.size() - b0 == 2 && stalled < stall_len) begin
        out_ready = 1'b0; stalled++;
      end else out_ready = 1'b1;
      if (poke && t == 2) begin start = 1'b1; base_addr = 32'h0; word_count = 16'd3; end
      else start = 1'b0;
      if (do_reset && byte_q.size() - b0 == 2) begin
        #2 rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_byte", out_byte, 0);
        check("rst_last", out_last, 0);
        rst_hit = 1;
      end else begin
        @(posedge clk); #1; t++;
      end
    end
    out_ready = 1'b1; start = 1'b0;
    if (!rst_hit) check("timeout", t < 400, 1);
  endtask

  task automatic verify(input string tag);
    int n;
    logic [31:0] got;
    repeat (6) @(posedge clk);
    #1;
    n = exp_b.size();
    check({tag, "_nbytes"}, byte_q.size() - b0, n);
    for (int i = 0; i < n; i++) begin
      got = (b0 + i < byte_q.size()) ? {24'h0, byte_q[b0 + i]} : 32'hFFFF_FFFF;
      check($sformatf("%s_byte%0d", tag, i), got, {24'h0, exp_b[i]});
      got = (b0 + i < last_q.size()) ? {31'h0, last_q[b0 + i]} : 32'hFFFF_FFFF;
      check($sformatf("%s_last%0d", tag, i), got, (i == n - 1) ? 1 : 0);
    end
    check({tag, "_naddr"}, addr_q.size() - a0, exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      got = (a0 + i < addr_q.size()) ? addr_q[a0 + i] : 32'hDEAD_BEEF;
      check($sformatf("%s_addr%0d", tag, i), got, exp_a[i]);
    end
    check({tag, "_done_pulses"}, done_n - d0, 1);
    check({tag, "_rd_single"}, rd_err, 0);
    if (n > 0) check({tag, "_done_after_last"}, done_cyc - last_hs_cyc, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[5]   = 32'h1122_3344;   // 0x14
    mem[0]   = 32'h0000_0005;
    mem[1]   = 32'h0000_0004;
    mem[2]   = 32'h0000_0007;
    mem[255] = 32'hA1B2_C3D4;   // 0xFFFFFFFC

    rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
    #23;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_en", mem_rd_en, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_valid", out_valid, 0);
    check("reset_byte", out_byte, 0);
    check("reset_last", out_last, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Single word
    exp_clear(); exp_word(32'h14, 32'h1122_3344); exp_finish();
    run_dump(32'h14, 16'd1, 0, 0, 0);
    verify("single");
    check("first_valid_latency", (rise_q.size() > r0) ? rise_q[r0] - start_cyc : -1, 3);

    // Three words, full throughput
    exp_clear();
    exp_word(32'h0, 32'h5); exp_word(32'h4, 32'h4); exp_word(32'h8, 32'h7);
    exp_finish();
    run_dump(32'h0, 16'd3, 0, 0, 0);
    verify("three");
`ifdef DUMP_CHECKSUM_EN
    check("three_total_cycles", done_cyc - start_cyc, 20);
`else
    check("three_total_cycles", done_cyc - start_cyc, 19);
`endif

    // Backpressure: 5 stalled cycles on byte 2
    exp_clear(); exp_word(32'h14, 32'h1122_3344); exp_finish();
    run_dump(32'h14, 16'd1, 5, 0, 0);
    verify("stall");
    check("stall_cycles", stall_seen - s0, 5);
    check("stall_stable", stab_err, 0);

    // word_count = 0
    exp_clear(); exp_finish();
    run_dump(32'h40, 16'd0, 0, 0, 0);
    verify("zero");
`ifndef DUMP_CHECKSUM_EN
    check("zero_no_valid", rise_q.size() - r0, 0);
`endif

    // Unaligned base
    exp_clear(); exp_word(32'h14, 32'h1122_3344); exp_finish();
    run_dump(32'h17, 16'd1, 0, 0, 0);
    verify("unaligned");

    // Address wrap
    exp_clear(); exp_word(32'hFFFF_FFFC, 32'hA1B2_C3D4); exp_word(32'h0, 32'h5); exp_finish();
    run_dump(32'hFFFF_FFFC, 16'd2, 0, 0, 0);
    verify("wrap");

    // Reset during byte 2 of a dump
    b0 = byte_q.size();
    run_dump(32'h0, 16'd3, 0, 1, 0);
    check("rst_hit", rst_hit, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_bytes_before", byte_q.size() - b0, 2);
    check("rst_no_done", done_n - d0, 0);
    check("rst_idle", busy, 0);

    // Fresh dump after reset, with a start pulse while busy
    exp_clear(); exp_word(32'h14, 32'h1122_3344); exp_finish();
    run_dump(32'h14, 16'd1, 0, 0, 1);
    verify("poke");
    repeat (10) @(posedge clk);
    #1;
    check("poke_no_new_read", addr_q.size() - a0, 1);
    check("poke_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
